// File: rtl/rnn_pkg.sv
// Shared types, address map and fixed-point helpers for the sequential RNN cell.
package rnn_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t BUSY      = 3'd1;
  localparam state_t WRITEBACK = 3'd2;
  localparam state_t COMMIT    = 3'd3;
  localparam state_t DONE      = 3'd4;

  localparam logic [31:0] ADDR_CTRL = 32'd0;
  localparam logic [31:0] ADDR_X    = 32'd1;
  localparam logic [31:0] ADDR_W    = 32'd2;
  localparam logic [31:0] ADDR_U    = 32'd3;
  localparam logic [31:0] ADDR_RIDX = 32'd4;
  localparam logic [31:0] ADDR_H    = 32'd5;

  localparam int unsigned ACT_LINEAR = 0;
  localparam int unsigned ACT_RELU   = 1;
  localparam int unsigned ACT_HTANH  = 2;

  function automatic logic signed [15:0] sat16(input logic signed [63:0] v);
    if (v > 64'sd32767) return 16'sh7fff;
    if (v < -64'sd32768) return 16'sh8000;
    return v[15:0];
  endfunction

  function automatic logic signed [15:0] act(input logic signed [15:0] v,
                                             input int unsigned mode,
                                             input int unsigned frac);
    logic signed [16:0] v17;
    logic signed [16:0] lim;
    logic signed [16:0] nlim;
    v17  = 17'(v);
    lim  = 17'sd1 <<< frac;
    nlim = -lim;
    if (mode == ACT_RELU) begin
      return (v < 16'sd0) ? 16'sd0 : v;
    end else if (mode == ACT_HTANH) begin
      // With FRAC=15 the limit is 32768, which sat16 has already made unreachable.
      if (v17 > lim) return lim[15:0];
      if (v17 < nlim) return nlim[15:0];
      return v;
    end
    return v;
  endfunction

endpackage

// File: rtl/rnn_cell_seq_mac.sv
// Single time-shared MAC with shift / saturate / activation output stage.
module rnn_mac
  import rnn_pkg::*;
#(
  parameter int unsigned FRAC     = 0,
  parameter int unsigned ACC_W    = 40,
  parameter int unsigned ACT_MODE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic signed [15:0] a,
  input  logic signed [15:0] b,
  output logic signed [15:0] result
);

  logic signed [31:0]      prod;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] shifted;

  assign prod = a * b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_q + ACC_W'(prod);
    end
  end

  assign shifted = acc_q >>> FRAC;
  assign result  = act(sat16(64'(shifted)), ACT_MODE, FRAC);

endmodule

// File: rtl/rnn_cell_seq.sv
// Memory-mapped recurrent cell: h_t = act(W*x + U*h_{t-1}), one MAC per cycle.
module rnn_cell_seq
  import rnn_pkg::*;
#(
  parameter int unsigned IN_DIM   = 2,
  parameter int unsigned HID_DIM  = 4,
  parameter int unsigned FRAC     = 0,
  parameter int unsigned ACC_W    = 40,
  parameter int unsigned ACT_MODE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  localparam int unsigned IW = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int unsigned HW = (HID_DIM > 1) ? $clog2(HID_DIM) : 1;
  localparam int unsigned KW = $clog2(IN_DIM + HID_DIM);

  logic signed [15:0] x_q  [IN_DIM];
  logic signed [15:0] w_q  [IN_DIM][HID_DIM];
  logic signed [15:0] u_q  [HID_DIM][HID_DIM];
  logic signed [15:0] h_q  [HID_DIM];
  logic signed [15:0] hn_q [HID_DIM];

  state_t          state_q;
  logic            busy_q, done_q;
  logic [HW-1:0]   j_q, ridx_q;
  logic [KW-1:0]   k_q, kh;

  logic            idle, wr_ctrl, start, clear;
  logic [7:0]      row, col;
  logic            row_in_x, row_in_h, col_in_h, xidx_ok, k_is_x;
  logic signed [15:0] mac_a, mac_b, mac_result;

  assign idle     = (state_q == IDLE) || (state_q == DONE);
  assign wr_ctrl  = write && (addr == ADDR_CTRL) && idle;
  assign start    = wr_ctrl && data_in[0];
  assign clear    = wr_ctrl && data_in[1];
  assign row      = data_in[31:24];
  assign col      = data_in[23:16];
  assign row_in_x = {1'b0, row} < 9'(IN_DIM);
  assign row_in_h = {1'b0, row} < 9'(HID_DIM);
  assign col_in_h = {1'b0, col} < 9'(HID_DIM);
  assign xidx_ok  = {1'b0, data_in[31:16]} < 17'(IN_DIM);

  // k walks the concatenated [x; h_{t-1}] vector for hidden column j.
  assign k_is_x = k_q < KW'(IN_DIM);
  assign kh     = k_q - KW'(IN_DIM);
  assign mac_a  = k_is_x ? x_q[k_q[IW-1:0]] : h_q[kh[HW-1:0]];
  assign mac_b  = k_is_x ? w_q[k_q[IW-1:0]][j_q] : u_q[kh[HW-1:0]][j_q];

  rnn_mac #(
    .FRAC    (FRAC),
    .ACC_W   (ACC_W),
    .ACT_MODE(ACT_MODE)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start || (state_q == WRITEBACK)),
    .en    (state_q == BUSY),
    .a     (mac_a),
    .b     (mac_b),
    .result(mac_result)
  );

  // Operand memories; frozen while a step is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < IN_DIM; r++) begin
        x_q[r] <= '0;
        for (int c = 0; c < HID_DIM; c++) w_q[r][c] <= '0;
      end
      for (int r = 0; r < HID_DIM; r++) begin
        for (int c = 0; c < HID_DIM; c++) u_q[r][c] <= '0;
      end
      ridx_q <= '0;
    end else begin
      if (write && idle) begin
        if (addr == ADDR_X && xidx_ok) x_q[data_in[16+IW-1:16]] <= data_in[15:0];
        if (addr == ADDR_W && row_in_x && col_in_h) w_q[row[IW-1:0]][col[HW-1:0]] <= data_in[15:0];
        if (addr == ADDR_U && row_in_h && col_in_h) u_q[row[HW-1:0]][col[HW-1:0]] <= data_in[15:0];
      end
      if (write && addr == ADDR_RIDX && ({1'b0, data_in[7:0]} < 9'(HID_DIM))) begin
        ridx_q <= data_in[HW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      j_q     <= '0;
      k_q     <= '0;
      for (int i = 0; i < HID_DIM; i++) begin
        h_q[i]  <= '0;
        hn_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE, DONE: begin
          // Clear lands on the same edge as start, so the step sees h = 0.
          if (clear) begin
            for (int i = 0; i < HID_DIM; i++) h_q[i] <= '0;
          end
          if (start) begin
            state_q <= BUSY;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            j_q     <= '0;
            k_q     <= '0;
          end
        end
        BUSY: begin
          if (k_q == KW'(IN_DIM + HID_DIM - 1)) state_q <= WRITEBACK;
          else k_q <= k_q + KW'(1);
        end
        WRITEBACK: begin
          hn_q[j_q] <= mac_result;
          if (j_q == HW'(HID_DIM - 1)) begin
            state_q <= COMMIT;
          end else begin
            j_q     <= j_q + HW'(1);
            k_q     <= '0;
            state_q <= BUSY;
          end
        end
        COMMIT: begin
          for (int i = 0; i < HID_DIM; i++) h_q[i] <= hn_q[i];
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (read) begin
      if (addr == ADDR_CTRL) data_out <= {30'b0, done_q, busy_q};
      else if (addr == ADDR_H) data_out <= {{16{h_q[ridx_q][15]}}, h_q[ridx_q]};
      else data_out <= '0;
    end
  end

endmodule
